// File: rtl/stream_pkg.sv
// Shared definitions for the serial bit streamer: FSM state encoding and a
// ceiling-log2 helper used to size the bit counter.
package stream_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Ceiling of log2(value); value is expected to be at least 2.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 32'd0;
    rem    = value - 32'd1;
    while (rem > 32'd0) begin
      result = result + 32'd1;
      rem    = rem >> 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bit_shift_reg.sv
// Shift register plus bit counter for one word. Presents the current bit
// (ordered by LSB_FIRST) and flags the last bit of the word. Clearing the
// register zeroes the presented bit so the stream idles at 0.
module bit_shift_reg
  import stream_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic             clear_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_word,
  output logic             ser_bit,
  output logic             last_bit
);

  localparam int CW = clog2_f(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  // Next shift-register/counter value: load beats clear beats shift.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_en) begin
      shreg_d = load_word;
      cnt_d   = {CW{1'b0}};
    end else if (clear_en) begin
      shreg_d = {WIDTH{1'b0}};
      cnt_d   = {CW{1'b0}};
    end else if (shift_en) begin
      if (LSB_FIRST) begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end else begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end
      if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
    end
  end

  // Shift register and counter flops with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign last_bit = (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_bit_streamer.sv
// Parallel-in, serial-out streamer: accepts words over valid/ready and emits
// them one bit per clock. A one-word holding register lets the next word
// follow the current one with no idle cycle.
module serial_bit_streamer
  import stream_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data,
  output logic             data_valid,
  output logic             word_done,
  output logic             busy
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_d;
  logic             hold_full_q;
  logic             hold_full_d;

  logic             accept_s;
  logic             load_en_s;
  logic             clear_en_s;
  logic             shift_en_s;
  logic [WIDTH-1:0] load_word_s;
  logic             ser_bit_s;
  logic             last_bit_s;

  // Reset gates readiness so no word is taken during a reset cycle.
  assign load_ready = ~hold_full_q & ~reset;
  assign accept_s   = load_valid & load_ready;

  // Next state, holding register and shift-register controls.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load_en_s   = 1'b0;
    clear_en_s  = 1'b0;
    shift_en_s  = 1'b0;
    load_word_s = load_data;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          load_en_s = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          // The held word always wins; readiness is low while it waits.
          if (hold_full_q) begin
            load_en_s   = 1'b1;
            load_word_s = hold_q;
            hold_full_d = 1'b0;
          end else if (accept_s) begin
            load_en_s = 1'b1;
          end else begin
            clear_en_s = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          shift_en_s = 1'b1;
          if (accept_s) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end else begin
            hold_full_d = hold_full_q;
          end
        end
      end
      default: begin
        clear_en_s = 1'b1;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // FSM state and holding register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= {WIDTH{1'b0}};
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  bit_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clock     (clock),
    .reset     (reset),
    .load_en   (load_en_s),
    .clear_en  (clear_en_s),
    .shift_en  (shift_en_s),
    .load_word (load_word_s),
    .ser_bit   (ser_bit_s),
    .last_bit  (last_bit_s)
  );

  assign data       = ser_bit_s;
  assign data_valid = (state_q == ST_SHIFT);
  assign word_done  = data_valid & last_bit_s;
  assign busy       = data_valid | hold_full_q;

endmodule

// File: tb/tb_serial_bit_streamer.sv
// Bench for serial_bit_streamer: a 16-bit LSB-first instance and an 8-bit
// MSB-first instance, checked every cycle against a queue-based model of the
// bit stream, plus literal checks of the captured streams.
module tb_serial_bit_streamer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        sel;
  logic        rst_i;
  logic        vld_i;
  logic [63:0] word_i;

  logic        rst16, vld16, rdy16, d16, dv16, wd16, b16;
  logic [15:0] ld16;
  logic        rst8, vld8, rdy8, d8, dv8, wd8, b8;
  logic [7:0]  ld8;

  assign rst16 = sel ? 1'b1 : rst_i;
  assign vld16 = vld_i & ~sel;
  assign ld16  = word_i[15:0];
  assign rst8  = sel ? rst_i : 1'b1;
  assign vld8  = vld_i & sel;
  assign ld8   = word_i[7:0];

  serial_bit_streamer #(.WIDTH(16), .LSB_FIRST(1'b1)) dut16 (
    .clock(clock), .reset(rst16), .load_data(ld16), .load_valid(vld16),
    .load_ready(rdy16), .data(d16), .data_valid(dv16), .word_done(wd16), .busy(b16));

  serial_bit_streamer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
    .clock(clock), .reset(rst8), .load_data(ld8), .load_valid(vld8),
    .load_ready(rdy8), .data(d8), .data_valid(dv8), .word_done(wd8), .busy(b8));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: bits still to appear for the current word, and words waiting.
  bit          cur_q[$];
  logic [63:0] pend_q[$];
  int          acc_cnt = 0;

  // Capture of what the active DUT emitted since the last clear.
  bit cap[$];
  int cyc_idx = 0;
  int base = 0;
  int nvalid, nwd, nbusy, nrlow, first_v, last_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] w);
    int width;
    width = sel ? 8 : 16;
    for (int i = 0; i < width; i++) begin
      cur_q.push_back(sel ? w[width-1-i] : w[i]);
    end
  endtask

  task automatic clr_cap();
    cap.delete();
    base = cyc_idx;
    nvalid = 0; nwd = 0; nbusy = 0; nrlow = 0;
    first_v = -1; last_v = -1;
  endtask

  function automatic logic [63:0] pack_lsb(input int start, input int n);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v[i] = cap[start+i];
    return v;
  endfunction

  function automatic logic [63:0] pack_msb(input int start, input int n);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = {v[62:0], cap[start+i]};
    return v;
  endfunction

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic cyc(input logic r, input logic v, input logic [63:0] w);
    logic [4:0] act;
    logic [4:0] exp;
    logic       ev;
    logic       exp_rdy;
    logic       acc;
    int         rel;
    rst_i = r; vld_i = v; word_i = w;
    #3;
    ev      = (cur_q.size() > 0);
    exp_rdy = (pend_q.size() == 0) & ~r;
    exp     = {ev ? cur_q[0] : 1'b0, ev, (cur_q.size() == 1),
               ev | (pend_q.size() > 0), exp_rdy};
    act     = sel ? {d8, dv8, wd8, b8, rdy8} : {d16, dv16, wd16, b16, rdy16};
    check("outputs{data,valid,done,busy,ready}", {59'd0, act}, {59'd0, exp});
    rel = cyc_idx - base;
    if (act[3]) begin
      cap.push_back(act[4]);
      nvalid++;
      if (first_v < 0) first_v = rel;
      last_v = rel;
    end
    if (act[2]) nwd++;
    if (act[1]) nbusy++;
    if (!act[0]) nrlow++;
    if (r) begin
      cur_q.delete();
      pend_q.delete();
    end else begin
      acc = v & exp_rdy;
      if (acc) acc_cnt++;
      if (cur_q.size() > 0) void'(cur_q.pop_front());
      if (cur_q.size() == 0) begin
        if (pend_q.size() > 0) push_word(pend_q.pop_front());
        else if (acc) begin
          push_word(w);
          acc = 1'b0;
        end
      end
      if (acc) pend_q.push_back(w);
    end
    @(posedge clock);
    #1;
    cyc_idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 64'd0);
  endtask

  initial begin
    int target;
    sel = 1'b0; rst_i = 1'b1; vld_i = 1'b0; word_i = 64'd0;
    @(posedge clock);
    #1;

    // Valid held during reset: nothing taken until reset drops.
    clr_cap();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 64'h5555);
    check("rst_no_valid", nvalid, 0);
    clr_cap();
    cyc(1'b0, 1'b1, 64'h5555);
    idle(18);
    check("rst_first_bit_latency", first_v, 1);
    check("rst_word", pack_lsb(0, 16), 64'h5555);

    // Single word, LSB first.
    cyc(1'b1, 1'b0, 64'd0);
    cyc(1'b1, 1'b0, 64'd0);
    clr_cap();
    cyc(1'b0, 1'b1, 64'hA6B5);
    idle(18);
    check("t1_nvalid", nvalid, 16);
    check("t1_first", first_v, 1);
    check("t1_last", last_v, 16);
    check("t1_word_done", nwd, 1);
    check("t1_stream", pack_lsb(0, 16), 64'hA6B5);

    // Back-to-back through the holding register.
    clr_cap();
    cyc(1'b0, 1'b1, 64'hA6B5);
    idle(3);
    cyc(1'b0, 1'b1, 64'h00FF);
    idle(35);
    check("t2_nvalid", nvalid, 32);
    check("t2_contig", last_v - first_v + 1, 32);
    check("t2_word_done", nwd, 2);
    check("t2_w1", pack_lsb(0, 16), 64'hA6B5);
    check("t2_w2", pack_lsb(16, 16), 64'h00FF);

    // Three words with load_valid held high.
    clr_cap();
    target = acc_cnt + 3;
    cyc(1'b0, 1'b1, 64'h1111);
    cyc(1'b0, 1'b1, 64'h2222);
    for (int i = 0; i < 40 && acc_cnt < target; i++) cyc(1'b0, 1'b1, 64'h3333);
    check("t3_accept_bound", acc_cnt, target);
    idle(50);
    check("t3_nvalid", nvalid, 48);
    check("t3_contig", last_v - first_v + 1, 48);
    check("t3_word_done", nwd, 3);
    check("t3_ready_low", nrlow, 30);
    check("t3_w3", pack_lsb(32, 16), 64'h3333);

    // Reset in the middle of a word with the holding register full.
    clr_cap();
    cyc(1'b0, 1'b1, 64'hFFFF);
    cyc(1'b0, 1'b1, 64'h1234);
    idle(6);
    cyc(1'b1, 1'b0, 64'd0);
    clr_cap();
    idle(20);
    check("t4_no_residual", nvalid, 0);
    check("t4_not_busy", nbusy, 0);
    check("t4_ready", nrlow, 0);

    // Random traffic on the 16-bit instance.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), {$urandom, $urandom});
    idle(40);

    // MSB-first, 8-bit instance.
    sel = 1'b1;
    cyc(1'b1, 1'b0, 64'd0);
    cyc(1'b1, 1'b0, 64'd0);
    clr_cap();
    cyc(1'b0, 1'b1, 64'h81);
    cyc(1'b0, 1'b1, 64'h40);
    idle(20);
    check("t5_nvalid", nvalid, 16);
    check("t5_word_done", nwd, 2);
    check("t5_stream", pack_msb(0, 16), 64'h8140);

    // Random traffic on the 8-bit instance.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), {$urandom, $urandom});
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
